alu_ctrl: RTL
=============

# alu_ctrl

Command sequencer and register file that sits directly upstream and downstream of the 4-bit ALU. It accepts ALU commands over a valid/ready handshake and reads operands from a small register file. It drives the ALU's `a`/`b`/`opcode` inputs, captures `y`/`carryOut` back into a destination register, and returns the result over a second valid/ready handshake. The ALU itself is instantiated alongside, not inside, this block.

## Interface
Parameters:
- `NREG`, default 4: register count; legal values 2, 4, 8. `AW = $clog2(NREG)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: ALU opcode. 00 add, 01 sub, 10 AND, 11 OR.
- `cmd_src_a` in AW: register index for operand a.
- `cmd_src_b` in AW: register index for operand b.
- `cmd_imm_sel` in 1: 1 = use `cmd_imm` as operand b.
- `cmd_imm` in 4: immediate operand b.
- `cmd_dst` in AW: destination register index.
- `ld_en` in 1: direct register load strobe.
- `ld_addr` in AW: load index.
- `ld_data` in 4: load value.
- `alu_a` out 4: to ALU `a`.
- `alu_b` out 4: to ALU `b`.
- `alu_opcode` out 2: to ALU `opcode`.
- `alu_y` in 4: from ALU `y`.
- `alu_carry` in 1: from ALU `carryOut`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts result.
- `res_data` out 4: captured `alu_y`.
- `res_carry` out 1: captured `alu_carry`.
- `z_flag` out 1: zero flag (see Configuration).

## Operation
- FSM states: IDLE, EXEC, RESP. The reset state is IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`, latch `op`, `src_a`, `src_b`, `imm_sel`, `imm` and `dst`, then go to EXEC.
- EXEC (exactly one cycle):
  - `cmd_ready`=0.
  - `alu_a` = `regs[src_a]`.
  - `alu_b` = `imm_sel` ? `imm` : `regs[src_b]`.
  - `alu_opcode` = latched `op`.
  - At the end of the cycle: `regs[dst]` ← `alu_y`, `res_data` ← `alu_y`, `res_carry` ← `alu_carry`, then go to RESP.
- RESP:
  - `res_valid`=1 and `cmd_ready`=0.
  - On `res_ready`, go to IDLE and drop `res_valid`.
  - `res_data` and `res_carry` hold stable while `res_valid`=1, and keep their last values afterwards.
- `alu_a`, `alu_b` and `alu_opcode` are combinational from the latched command and the register file in every state. Only EXEC values are consumed.
- Register file is `NREG` × 4 bits.
- Load port:
  - `ld_en` writes `regs[ld_addr]` ← `ld_data` in IDLE and RESP.
  - `ld_en` is ignored in EXEC, so the writeback never collides with a load.
- The `src_a`, `src_b` and `dst` indices may alias. Operands are read in EXEC before the writeback edge.
- Arithmetic is fully delegated to the ALU. Results are 4-bit modulo 16; the block applies no extension or saturation.

## Timing
- Command accepted at edge N. EXEC occupies cycle N..N+1. Writeback and `res_valid`=1 occur at edge N+1.
- Earliest next accept is the edge after the `res_ready` handshake. Peak throughput is 1 command per 3 cycles.
- `ld_en` and a command accept at the same IDLE edge: the load is written at that edge, and EXEC reads the loaded value.
- `ld_en` in RESP to the just-written `dst` overwrites the register. `res_data` is unaffected.
- `res_ready` asserted while not in RESP has no effect.
- Asynchronous reset, at any time including mid-EXEC or mid-RESP:
  - State goes to IDLE and all registers go to 0.
  - Latched command goes to 0, so `alu_a`/`alu_b`/`alu_opcode` = 0.
  - `res_valid`=0, `res_data`=0, `res_carry`=0, `z_flag`=0, `cmd_ready`=1.
  - Any in-flight command is discarded.

## Configuration
- `ALU_CTRL_ZERO_FLAG_EN` defined:
  - `z_flag` is a register updated at the EXEC writeback edge to (`alu_y` == 0).
  - It holds otherwise and is unaffected by `ld_en`.
- `ALU_CTRL_ZERO_FLAG_EN` undefined: the `z_flag` port exists but is tied to 0, and no flag register is built.

## Test plan
- Reset then load: `ld` r0=5, r1=3; command add r2=r0+r1 → `res_valid` at accept+1 edge, `res_data`=8, `res_carry`=0, r2=8.
- Carry and wrap: r0=0xC, r1=0x6, add → `res_data`=0x2, `res_carry`=1. Sub of r1−r0 gives `res_data`=0xA, with carry as produced by the ALU.
- Logic with immediate: r0=0xA, `imm_sel`=1, `imm`=0x6, AND → `res_data`=0x2, `res_carry`=0, and `z_flag`=0. Next: r0 AND `imm` 0x5 → `res_data`=0, `z_flag`=1 (macro on) or 0 (macro off).
- Backpressure: hold `res_ready`=0 for 5 cycles → `res_valid`, `res_data` stable and `cmd_ready`=0 throughout, with a second `cmd_valid` pending. After `res_ready` the second command is accepted 1 cycle later.
- Aliasing and collisions: `ld_en` in IDLE at the accept edge with `ld_addr`=`src_a` → EXEC uses the loaded value. `ld_en` during EXEC → ignored. `dst`=`src_a`=r3 (value 7), add imm 1 → r3=8.
- Reset mid-operation: assert `rst_n`=0 during EXEC → all outputs 0, `cmd_ready`=1, registers 0, and no `res_valid` after release.

Source files
------------

// File: rtl/alu_ctrl.sv
// Command sequencer and register file wrapped around an external 4-bit ALU.
// Optional zero flag register: define ALU_CTRL_ZERO_FLAG_EN to build it.
module alu_ctrl #(
    parameter  int NREG = 4,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_src_a,
    input  logic [AW-1:0] cmd_src_b,
    input  logic          cmd_imm_sel,
    input  logic [3:0]    cmd_imm,
    input  logic [AW-1:0] cmd_dst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [3:0]    ld_data,
    output logic [3:0]    alu_a,
    output logic [3:0]    alu_b,
    output logic [1:0]    alu_opcode,
    input  logic [3:0]    alu_y,
    input  logic          alu_carry,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [3:0]    res_data,
    output logic          res_carry,
    output logic          z_flag
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [1:0]    op_p0;
    logic [AW-1:0] src_a_p0;
    logic [AW-1:0] src_b_p0;
    logic          imm_sel_p0;
    logic [3:0]    imm_p0;
    logic [AW-1:0] dst_p0;
    logic [3:0]    regs [NREG];

    logic accept;
    logic exec;

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == RESP);
    assign accept    = cmd_valid && cmd_ready;
    assign exec      = (state == EXEC);

    // Operands are driven continuously; the ALU result is only consumed in EXEC.
    assign alu_a      = regs[src_a_p0];
    assign alu_b      = imm_sel_p0 ? imm_p0 : regs[src_b_p0];
    assign alu_opcode = op_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (cmd_valid) state <= EXEC;
                EXEC:    state <= RESP;
                RESP:    if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p0      <= '0;
            src_a_p0   <= '0;
            src_b_p0   <= '0;
            imm_sel_p0 <= 1'b0;
            imm_p0     <= '0;
            dst_p0     <= '0;
        end else if (accept) begin
            op_p0      <= cmd_op;
            src_a_p0   <= cmd_src_a;
            src_b_p0   <= cmd_src_b;
            imm_sel_p0 <= cmd_imm_sel;
            imm_p0     <= cmd_imm;
            dst_p0     <= cmd_dst;
        end
    end

    // Writeback owns the register file in EXEC, so loads are dropped there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (exec) begin
            regs[dst_p0] <= alu_y;
        end else if (ld_en) begin
            regs[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data  <= '0;
            res_carry <= 1'b0;
        end else if (exec) begin
            res_data  <= alu_y;
            res_carry <= alu_carry;
        end
    end

`ifdef ALU_CTRL_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_flag <= 1'b0;
        end else if (exec) begin
            z_flag <= (alu_y == 4'd0);
        end
    end
`else
    assign z_flag = 1'b0;
`endif

endmodule
